// File: rtl/accel_spi_pkg.sv
// accel_spi_pkg: state encoding, command-byte layout and register
// constants shared by the accelerometer SPI reader.
package accel_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT_FRAME,
    WAIT_TICK,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CS_GAP
  } state_t;

  localparam int R_BIT  = 7;
  localparam int MB_BIT = 6;

  localparam logic [7:0] ADDR_DATAX0       = 8'h32;
  localparam logic [7:0] ADDR_POWER_CTL    = 8'h2D;
  localparam logic [7:0] POWER_CTL_MEASURE = 8'h08;

  // Reads are multi-byte, writes single-byte, so MB follows R.
  function automatic logic [7:0] cmd_byte(
    input logic       rd,
    input logic [5:0] addr
  );
    logic [7:0] c;
    c         = {2'b00, addr};
    c[R_BIT]  = rd;
    c[MB_BIT] = rd;
    return c;
  endfunction

  function automatic logic in_frame(input state_t s);
    return s inside {INIT_FRAME, CS_SETUP, SHIFT, CS_HOLD};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: generic mode-3 shifter, MSB first, runtime bit count,
// SCLK half-period of CLK_DIV clocks; done is high in the final cycle.
module spi_shift_engine #(
  parameter int N       = 24,
  parameter int CLK_DIV = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [$clog2(N+1)-1:0] bits,
  input  logic [N-1:0]           tx,
  output logic [N-1:0]           rx,
  output logic                   done,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int BW = $clog2(N + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  logic          run;
  logic [DW-1:0] div;
  logic [BW-1:0] left;
  logic [N-1:0]  sreg;
  logic          half_end;

  assign half_end = run && (div == DW'(CLK_DIV - 1));
  assign done     = half_end && sclk && (left == '0);

  // start drives the first falling edge on the same clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run  <= 1'b0;
      div  <= '0;
      left <= '0;
      sreg <= '0;
      rx   <= '0;
      sclk <= 1'b1;
      mosi <= 1'b1;
    end else if (start) begin
      run  <= 1'b1;
      div  <= '0;
      left <= bits - 1'b1;
      sreg <= {tx[N-2:0], 1'b1};
      sclk <= 1'b0;
      mosi <= tx[N-1];
    end else if (half_end) begin
      div <= '0;
      if (!sclk) begin
        sclk <= 1'b1;
        rx   <= {rx[N-2:0], miso};
      end else if (left == '0) begin
        run  <= 1'b0;
        mosi <= 1'b1;
      end else begin
        sclk <= 1'b0;
        mosi <= sreg[N-1];
        sreg <= {sreg[N-2:0], 1'b1};
        left <= left - 1'b1;
      end
    end else if (run) begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/accel_spi_reader.sv
// accel_spi_reader: periodic mode-3 SPI read of one accelerometer axis.
// Define ACCEL_INIT_EN to issue one config write after every reset.
module accel_spi_reader
  import accel_spi_pkg::*;
#(
  parameter int         WIDTH         = 32,
  parameter int         CLK_DIV       = 25,
  parameter int         SAMPLE_PERIOD = 50000,
  parameter logic [7:0] DATA_ADDR     = ADDR_DATAX0,
  parameter logic [7:0] INIT_ADDR     = ADDR_POWER_CTL,
  parameter logic [7:0] INIT_DATA     = POWER_CTL_MEASURE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             spi_sclk,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int FB = 24;
  localparam int BW = $clog2(FB + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);

  state_t        state, state_n;
  logic [DW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          tick, cnt_last, start, done, wr, rd_end;
  logic [BW-1:0] bits;
  logic [FB-1:0] tx, rx;

  assign tick     = enable && (tcnt == TW'(SAMPLE_PERIOD - 1));
  assign cnt_last = (cnt == DW'(CLK_DIV - 1));
  assign rd_end   = (state == CS_HOLD) && (state_n == CS_GAP) && !wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (!enable || tcnt == TW'(SAMPLE_PERIOD - 1)) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    bits    = BW'(FB);
    tx      = {cmd_byte(1'b1, DATA_ADDR[5:0]), 16'hFFFF};
    unique case (state)
`ifdef ACCEL_INIT_EN
      IDLE: state_n = INIT_FRAME;
      INIT_FRAME: begin
        bits = BW'(16);
        tx   = {cmd_byte(1'b0, INIT_ADDR[5:0]), INIT_DATA, 8'hFF};
        if (cnt_last) begin
          start   = 1'b1;
          state_n = SHIFT;
        end
      end
`else
      IDLE: state_n = WAIT_TICK;
`endif
      WAIT_TICK: if (tick) state_n = CS_SETUP;
      CS_SETUP: begin
        if (cnt_last) begin
          start   = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT:   if (done) state_n = CS_HOLD;
      CS_HOLD: if (cnt_last) state_n = CS_GAP;
      CS_GAP:  if (cnt_last) state_n = WAIT_TICK;
      default: state_n = IDLE;
    endcase
  end

`ifdef ACCEL_INIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr <= 1'b0;
    end else if (state_n == INIT_FRAME) begin
      wr <= 1'b1;
    end else if (state_n == CS_SETUP) begin
      wr <= 1'b0;
    end
  end
`else
  assign wr = 1'b0;
`endif

  // Low byte arrives first, so it sits above the high byte in rx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_cs_n     <= 1'b1;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
      overrun      <= 1'b0;
    end else begin
      spi_cs_n     <= !in_frame(state_n);
      busy         <= in_frame(state_n) || in_frame(state);
      sample_valid <= rd_end;
      if (rd_end) begin
        sample_out <= WIDTH'($signed({rx[7:0], rx[15:8]}));
      end
      if (tick && busy) begin
        overrun <= 1'b1;
      end
    end
  end

  spi_shift_engine #(
    .N      (FB),
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .bits (bits),
    .tx   (tx),
    .rx   (rx),
    .done (done),
    .sclk (spi_sclk),
    .mosi (spi_mosi),
    .miso (spi_miso)
  );

endmodule

// File: tb/tb_accel_spi_reader.sv
// tb_accel_spi_reader: randomized bench with a mode-3 slave model per DUT;
// expected samples and frame timing come from the frame rules.
`timescale 1ns/1ps
module tb_accel_spi_reader;

  localparam int CD     = 2;
  localparam int P      = 200;
  localparam int P2     = 50;
  localparam int RD_LEN = CD * 50;
  localparam int WR_LEN = CD * 34;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic enable2 = 1'b0;

  logic sclk, cs_n, mosi, sv, busy, ovr;
  logic sclk2, cs_n2, mosi2, sv2, busy2, ovr2;
  logic miso = 1'b1;
  logic miso2 = 1'b1;
  logic [31:0] sample_out, sample_out2;

  int cyc = 0;
  int rel_cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accel_spi_reader #(
    .WIDTH(32), .CLK_DIV(CD), .SAMPLE_PERIOD(P)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi), .spi_miso(miso),
    .sample_out(sample_out), .sample_valid(sv), .busy(busy),
    .overrun(ovr)
  );

  accel_spi_reader #(
    .WIDTH(32), .CLK_DIV(CD), .SAMPLE_PERIOD(P2)
  ) dut2 (
    .clk(clk), .reset(reset), .enable(enable2),
    .spi_sclk(sclk2), .spi_cs_n(cs_n2), .spi_mosi(mosi2), .spi_miso(miso2),
    .sample_out(sample_out2), .sample_valid(sv2), .busy(busy2),
    .overrun(ovr2)
  );

  // Mode-3 slaves: shift out on SCLK fall; low byte then high byte.
  logic [7:0]  s_lo = 8'h00, s_hi = 8'h00;
  logic [7:0]  s2_lo = 8'h80, s2_hi = 8'h7F;
  logic [23:0] s_sr, s2_sr;

  always @(negedge cs_n) s_sr = {8'h5A, s_lo, s_hi};
  always @(negedge sclk)
    if (cs_n === 1'b0) begin
      miso = s_sr[23];
      s_sr = {s_sr[22:0], 1'b0};
    end

  always @(negedge cs_n2) s2_sr = {8'hA5, s2_lo, s2_hi};
  always @(negedge sclk2)
    if (cs_n2 === 1'b0) begin
      miso2 = s2_sr[23];
      s2_sr = {s2_sr[22:0], 1'b0};
    end

  typedef struct {
    int          start;
    int          len;
    logic [31:0] mosi;
    int          nbits;
    int          nvalid;
    logic [31:0] sample;
    bit          at_rise;
    bit          timeout;
    int          sclk_bad;
  } frame_t;

  function automatic logic [31:0] ref_sample(input logic [7:0] lo,
                                             input logic [7:0] hi);
    int v;
    v = int'(hi) * 256 + int'(lo);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  task automatic capture_frame(input int drop_at, output frame_t f);
    int g;
    logic ps;
    f = '{default: 0};
    g = 0;
    while (cs_n === 1'b1 && g < 2000) begin
      if (sclk !== 1'b1) f.sclk_bad++;
      @(posedge clk); #1;
      g++;
    end
    if (cs_n !== 1'b0) begin
      f.timeout = 1;
      return;
    end
    f.start = cyc;
    ps = sclk;
    g = 0;
    while (cs_n === 1'b0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
      if (drop_at >= 0 && cyc - f.start == drop_at) enable = 1'b0;
      if (sclk === 1'b1 && ps === 1'b0) begin
        f.mosi = {f.mosi[30:0], mosi};
        f.nbits++;
      end
      if (sv === 1'b1) begin
        f.nvalid++;
        f.sample = sample_out;
        if (cs_n === 1'b1) f.at_rise = 1;
      end
      ps = sclk;
    end
    if (cs_n !== 1'b1) f.timeout = 1;
    f.len = cyc - f.start;
    @(posedge clk); #1;
    if (sv === 1'b1) f.nvalid++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({sclk, cs_n, mosi, sv, busy, ovr} !== 6'b111000) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 111000",
               {sclk, cs_n, mosi, sv, busy, ovr});
    end
    n_cmp++;
    if (sample_out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_sample got %h want 00000000", sample_out);
    end
    n_cmp++;
    if ({sclk2, cs_n2, mosi2, sv2, busy2, ovr2, sample_out2} !==
        {6'b111000, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_dut2 got %b %h want 111000 0",
               {sclk2, cs_n2, mosi2, sv2, busy2, ovr2}, sample_out2);
    end
  endtask

  task automatic test_init();
`ifdef ACCEL_INIT_EN
    frame_t f;
    capture_frame(-1, f);
    n_cmp++;
    if (f.timeout || f.start != rel_cyc + 1) begin
      n_bad++;
      $display("FAIL init_start got %0d want %0d (timeout=%0d)",
               f.start, rel_cyc + 1, f.timeout);
    end
    n_cmp++;
    if (f.nbits != 16 || f.mosi[15:0] !== 16'h2D08) begin
      n_bad++;
      $display("FAIL init_mosi got %0d bits %h want 16 bits 2d08",
               f.nbits, f.mosi[15:0]);
    end
    n_cmp++;
    if (f.len != WR_LEN) begin
      n_bad++;
      $display("FAIL init_len got %0d want %0d", f.len, WR_LEN);
    end
    n_cmp++;
    if (f.nvalid != 0) begin
      n_bad++;
      $display("FAIL init_valid got %0d want 0", f.nvalid);
    end
`else
    int act;
    act = 0;
    for (int i = 0; i < P - 20; i++) begin
      @(posedge clk); #1;
      if (cs_n !== 1'b1 || sv !== 1'b0 || sclk !== 1'b1) act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++;
      $display("FAIL noinit_quiet got %0d active cycles want 0", act);
    end
`endif
  endtask

  task automatic test_read();
    frame_t f;
    int prev, want;
    logic [7:0] lo, hi;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        lo = 8'h34; hi = 8'hF2;
      end else if (i == 1) begin
        lo = 8'hFF; hi = 8'h01;
      end else begin
        lo = 8'($urandom_range(0, 255));
        hi = 8'($urandom_range(0, 255));
      end
      s_lo = lo;
      s_hi = hi;
      capture_frame(-1, f);
      want = (i == 0) ? rel_cyc + P : prev + P;
      n_cmp++;
      if (f.timeout || f.start != want) begin
        n_bad++;
        $display("FAIL rd%0d_start got %0d want %0d", i, f.start, want);
      end
      n_cmp++;
      if (f.len != RD_LEN) begin
        n_bad++;
        $display("FAIL rd%0d_len got %0d want %0d", i, f.len, RD_LEN);
      end
      n_cmp++;
      if (f.nbits != 24 || f.mosi[23:16] !== 8'hF2) begin
        n_bad++;
        $display("FAIL rd%0d_cmd got %0d bits %h want 24 bits f2",
                 i, f.nbits, f.mosi[23:16]);
      end
      n_cmp++;
      if (f.nvalid != 1 || !f.at_rise) begin
        n_bad++;
        $display("FAIL rd%0d_valid got %0d at_rise=%0d want 1 1",
                 i, f.nvalid, f.at_rise);
      end
      n_cmp++;
      if (f.sample !== ref_sample(lo, hi)) begin
        n_bad++;
        $display("FAIL rd%0d_sample got %h want %h",
                 i, f.sample, ref_sample(lo, hi));
      end
      n_cmp++;
      if (f.sclk_bad != 0) begin
        n_bad++;
        $display("FAIL rd%0d_idle_sclk got %0d want 0", i, f.sclk_bad);
      end
      prev = f.start;
    end
    n_cmp++;
    if (ovr !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_overrun got %b want 0", ovr);
    end
  endtask

  task automatic test_reset_midframe();
    int g, rises, vcnt;
    logic ps;
    g = 0;
    while (cs_n === 1'b1 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    rises = 0;
    ps = sclk;
    while ((rises < 9 || sclk === 1'b1) && g < 3000) begin
      @(posedge clk); #1;
      g++;
      if (sclk === 1'b1 && ps === 1'b0) rises++;
      ps = sclk;
    end
    n_cmp++;
    if (cs_n !== 1'b0 || sclk !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reach got cs_n=%b sclk=%b want 0 0", cs_n, sclk);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({sclk, cs_n, mosi, sv, busy, ovr} !== 6'b111000) begin
      n_bad++;
      $display("FAIL mid_async got %b want 111000",
               {sclk, cs_n, mosi, sv, busy, ovr});
    end
    n_cmp++;
    if (sample_out !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_sample got %h want 00000000", sample_out);
    end
    vcnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (sv !== 1'b0 || cs_n !== 1'b1) vcnt++;
    end
    n_cmp++;
    if (vcnt != 0) begin
      n_bad++;
      $display("FAIL mid_hold got %0d active cycles want 0", vcnt);
    end
    release_reset();
    test_init();
  endtask

  task automatic test_enable_drop();
    frame_t f;
    int act;
    logic [7:0] lo, hi;
    lo = 8'($urandom_range(0, 255));
    hi = 8'($urandom_range(0, 255));
    s_lo = lo;
    s_hi = hi;
    capture_frame(20, f);
    n_cmp++;
    if (f.timeout || f.start != rel_cyc + P || f.len != RD_LEN) begin
      n_bad++;
      $display("FAIL drop_frame got start %0d len %0d want %0d %0d",
               f.start, f.len, rel_cyc + P, RD_LEN);
    end
    n_cmp++;
    if (f.nvalid != 1 || !f.at_rise || f.sample !== ref_sample(lo, hi)) begin
      n_bad++;
      $display("FAIL drop_sample got n=%0d %h want n=1 %h",
               f.nvalid, f.sample, ref_sample(lo, hi));
    end
    act = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(posedge clk); #1;
      if (cs_n !== 1'b1 || sclk !== 1'b1 || sv !== 1'b0 || busy !== 1'b0)
        act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++;
      $display("FAIL drop_quiet got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_overrun();
    int t0, k, gap, shortg, frames, nv, badv, clr;
    bit seen;
    logic [31:0] want;
    logic pcs;
    want = ref_sample(s2_lo, s2_hi);
    n_cmp++;
    if (ovr2 !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_init got %b want 0", ovr2);
    end
    @(negedge clk);
    enable2 = 1'b1;
    t0 = cyc;
    gap = 0; shortg = 0; frames = 0; nv = 0; badv = 0; clr = 0;
    seen = 0;
    pcs = cs_n2;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      k = cyc - t0;
      if (k == 60) begin
        n_cmp++;
        if (ovr2 !== 1'b0) begin
          n_bad++;
          $display("FAIL ovr_first_tick got %b want 0", ovr2);
        end
      end
      if (k == 110) begin
        n_cmp++;
        if (ovr2 !== 1'b1) begin
          n_bad++;
          $display("FAIL ovr_second_tick got %b want 1", ovr2);
        end
      end
      if (k > 110 && ovr2 !== 1'b1) clr++;
      if (cs_n2 === 1'b1) begin
        gap++;
      end else begin
        if (pcs === 1'b1) begin
          frames++;
          if (seen && gap < 2) shortg++;
        end
        seen = 1;
        gap = 0;
      end
      pcs = cs_n2;
      if (sv2 === 1'b1) begin
        nv++;
        if (sample_out2 !== want) badv++;
      end
    end
    enable2 = 1'b0;
    n_cmp++;
    if (clr != 0) begin
      n_bad++;
      $display("FAIL ovr_sticky got %0d cleared cycles want 0", clr);
    end
    n_cmp++;
    if (shortg != 0 || frames < 3) begin
      n_bad++;
      $display("FAIL ovr_gap got short=%0d frames=%0d want 0 >=3",
               shortg, frames);
    end
    n_cmp++;
    if (nv < 2 || badv != 0) begin
      n_bad++;
      $display("FAIL ovr_samples got n=%0d bad=%0d want >=2 0", nv, badv);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    test_reset();
    enable = 1'b1;
    release_reset();
    test_init();
    test_read();
    test_reset_midframe();
    test_enable_drop();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accel_spi_reader.md
# accel_spi_reader

- SPI mode-3 master that feeds sign-extended accelerometer samples into the FIR filter's `data_in`.
- Reads one 16-bit axis register from the accelerometer at a fixed sample rate.
- Presents each result as a `WIDTH`-bit signed word with a one-cycle valid strobe.
- Optionally performs one configuration-register write after reset before sampling starts.

## Interface
Parameters:
- `WIDTH`, 32, output sample width; must be ≥ 16.
- `CLK_DIV`, 25, `clk` cycles per SCLK half-period; must be ≥ 1.
- `SAMPLE_PERIOD`, 50000, `clk` cycles between read requests.
- `DATA_ADDR`, 8'h32, register address of the axis low byte.
- `INIT_ADDR`, 8'h2D, configuration register address.
- `INIT_DATA`, 8'h08, value written to `INIT_ADDR`.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  allows new read frames to start.
- `spi_sclk`  out  1  SPI clock; idles high.
- `spi_cs_n`  out  1  chip select, active low.
- `spi_mosi`  out  1  master data out.
- `spi_miso`  in  1  slave data in.
- `sample_out`  out  `WIDTH`  signed sample; holds its value between updates.
- `sample_valid`  out  1  one-cycle strobe; `sample_out` is new in that cycle.
- `busy`  out  1  high from `cs_n` fall until the cycle after `cs_n` rises.
- `overrun`  out  1  sticky; set when a sample tick arrives while `busy`; cleared only by reset.

## Operation
- States: `IDLE`, `INIT_FRAME` (only when `ACCEL_INIT_EN` is defined), `WAIT_TICK`, `CS_SETUP`, `SHIFT`, `CS_HOLD`, `CS_GAP`.
- Sample timer:
  - Counts 0..`SAMPLE_PERIOD`-1 and generates a tick on wrap.
  - Held at 0 while `enable`=0.
  - A tick while `busy` is dropped and sets `overrun`.
- Read frame is 24 bits, MSB first:
  - Command byte is {R=1, MB=1, `DATA_ADDR`[5:0]}.
  - Then 16 bits are received: low byte first, then high byte.
  - `sample_out` = sign-extend({high, low}) to `WIDTH`.
- Write frame (init) is 16 bits: {R=0, MB=0, `INIT_ADDR`[5:0]}, then `INIT_DATA`. MISO is ignored; no `sample_valid`.
- Mode 3 bit timing:
  - `spi_mosi` changes on the SCLK falling edge.
  - `spi_miso` is sampled on the SCLK rising edge.
  - The first falling edge comes `CLK_DIV` cycles after `cs_n` falls.
- Frame sequence:
  - After the last rising edge, `CS_HOLD` lasts `CLK_DIV` cycles, then `cs_n` rises.
  - `CS_GAP` keeps `cs_n` high for ≥ `CLK_DIV` cycles before any next frame.
- `enable` deasserted mid-frame: the frame completes normally, including `sample_valid`; no new frame starts.
- Reset values: `spi_sclk`=1, `spi_cs_n`=1, `spi_mosi`=1, `sample_out`=0, `sample_valid`=0, `busy`=0, `overrun`=0, state `IDLE`.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronously).
  - The partial sample is discarded.
  - The init frame re-runs after reset release.

## Timing
- Read frame length, from `cs_n` fall to `cs_n` rise: `CLK_DIV`·(1 + 48 + 1) cycles.
- `sample_valid` pulses in the same cycle that `cs_n` rises; `sample_out` updates on that edge.
- First frame starts 1 cycle after reset release:
  - With `ACCEL_INIT_EN`: the init frame; the first read follows the first timer tick after `CS_GAP`.
  - Without it: the first read follows the first timer tick.
- No SCLK edges occur while `cs_n` is high.
- Ticks are dropped (not queued) unless `SAMPLE_PERIOD` ≥ 51·`CLK_DIV` + 1.

## Configuration
- `ACCEL_INIT_EN`
  - Defined: `INIT_FRAME` state and the write-frame logic are compiled in; one write of `INIT_DATA` to `INIT_ADDR` runs after every reset.
  - Undefined: no write frame exists, `INIT_*` parameters are unused, and `IDLE` goes directly to `WAIT_TICK`.

## Structure
- Package `accel_spi_pkg`:
  - State enum.
  - R/MB bit positions.
  - Default register address constants (`0x32`, `0x2D`) and `POWER_CTL_MEASURE` = `8'h08`.
- Sub-module `spi_shift_engine`:
  - Generic mode-3 shifter: N-bit MOSI word in, N-bit MISO word out.
  - `start`/`done` handshake.
  - `CLK_DIV`-based SCLK generation.
  - The top level owns `cs_n`, sequencing and the sample timer.

## Test plan
Test settings: `CLK_DIV`=2, `SAMPLE_PERIOD`=200; the bench drives `spi_miso` with a mode-3 slave model.
1. Reset asserted → all outputs at their reset values; pulse reset mid-cycle → outputs change without waiting for a `clk` edge.
2. `ACCEL_INIT_EN` defined → first frame MOSI = 0x2D, 0x08; `cs_n` low for 2·(1+32+1)=68 cycles; no `sample_valid`.
3. Slave returns 0x34, 0xF2 → MOSI command 0xF2; `sample_out`=32'hFFFFF234 with `sample_valid` high for exactly 1 cycle, coincident with `cs_n` rise; frame is 100 cycles.
4. Slave returns 0xFF, 0x01 → `sample_out`=32'h000001FF; the next frame starts 200 cycles after the previous one (tick-aligned).
5. `SAMPLE_PERIOD`=50 → `overrun` sets after the second tick and stays set; frames are never back-to-back without a ≥2-cycle `cs_n` gap.
6. Reset during bit 10 of a read → `cs_n`=1 and `sclk`=1 immediately, no `sample_valid`; `enable` dropped mid-frame → that frame completes with one `sample_valid`, then no further `cs_n` activity.
